// File: rtl/bus_phase_sequencer.sv
// Sequences each external memory cycle over the pads as IDLE -> AH -> AL -> DATA -> IDLE.
// Optional wait-state support is compiled in with `define BUS_WAIT_STATE_EN.
module bus_phase_sequencer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    input  logic        ext_rdy,
    output logic [7:0]  pad_addr,
    input  logic [7:0]  pad_data_in,
    output logic [7:0]  pad_data_out,
    output logic [7:0]  pad_data_oe,
    output logic [1:0]  phase
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AH   = 2'd1,
        ST_AL   = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_MAX_C = 4'(WAIT_MAX);

    state_t      state_r, state_nxt_s;
    logic        we_r, we_nxt_s;
    logic [15:0] addr_r, addr_nxt_s;
    logic [7:0]  wdata_r, wdata_nxt_s;
    logic [7:0]  rdata_r, rdata_nxt_s;
    logic        done_r, done_nxt_s;
    logic        err_r, err_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic [7:0]  pad_addr_r, pad_addr_nxt_s;
    logic [7:0]  pad_dout_r, pad_dout_nxt_s;
    logic [7:0]  pad_oe_r, pad_oe_nxt_s;

`ifdef BUS_WAIT_STATE_EN
    logic [3:0]  wait_cnt_r, wait_cnt_nxt_s;
`else
    logic        unused_s;
    assign unused_s = ext_rdy ^ (^WAIT_MAX_C);
`endif

    // Next-state, transaction latch and completion logic
    always_comb begin
        state_nxt_s = state_r;
        we_nxt_s    = we_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        rdata_nxt_s = rdata_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
`ifdef BUS_WAIT_STATE_EN
        wait_cnt_nxt_s = wait_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_nxt_s = ST_AH;
                    we_nxt_s    = we;
                    addr_nxt_s  = addr;
                    wdata_nxt_s = wdata;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_AH: begin
                state_nxt_s = ST_AL;
            end
            ST_AL: begin
                state_nxt_s = ST_DATA;
`ifdef BUS_WAIT_STATE_EN
                wait_cnt_nxt_s = 4'd0;
`endif
            end
            ST_DATA: begin
`ifdef BUS_WAIT_STATE_EN
                // Ready is checked first so it wins on the limit edge
                if (ext_rdy) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                    if (!we_r) begin
                        rdata_nxt_s = pad_data_in;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                end else if (wait_cnt_r >= WAIT_MAX_C) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                    err_nxt_s   = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 4'd1;
                end
`else
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b1;
                if (!we_r) begin
                    rdata_nxt_s = pad_data_in;
                end else begin
                    rdata_nxt_s = rdata_r;
                end
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pad drive for the coming cycle, decoded from the next state so pads are registered
    always_comb begin
        pad_addr_nxt_s = 8'h00;
        pad_dout_nxt_s = 8'h00;
        pad_oe_nxt_s   = 8'h00;
        busy_nxt_s     = 1'b1;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_AH: begin
                pad_addr_nxt_s = addr_nxt_s[15:8];
                pad_dout_nxt_s = {7'b0000000, ~we_nxt_s};
                pad_oe_nxt_s   = 8'h01;
            end
            ST_AL, ST_DATA: begin
                pad_addr_nxt_s = addr_nxt_s[7:0];
                if (we_nxt_s) begin
                    pad_dout_nxt_s = wdata_nxt_s;
                    pad_oe_nxt_s   = 8'hFF;
                end else begin
                    pad_dout_nxt_s = 8'h00;
                    pad_oe_nxt_s   = 8'h00;
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // State, latched transaction and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            we_r       <= 1'b0;
            addr_r     <= 16'h0000;
            wdata_r    <= 8'h00;
            rdata_r    <= 8'h00;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            pad_addr_r <= 8'h00;
            pad_dout_r <= 8'h00;
            pad_oe_r   <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            we_r       <= we_nxt_s;
            addr_r     <= addr_nxt_s;
            wdata_r    <= wdata_nxt_s;
            rdata_r    <= rdata_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            busy_r     <= busy_nxt_s;
            pad_addr_r <= pad_addr_nxt_s;
            pad_dout_r <= pad_dout_nxt_s;
            pad_oe_r   <= pad_oe_nxt_s;
        end
    end

`ifdef BUS_WAIT_STATE_EN
    // Wait-state counter for the DATA phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 4'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end
`endif

    assign rdata        = rdata_r;
    assign done         = done_r;
    assign err          = err_r;
    assign busy         = busy_r;
    assign pad_addr     = pad_addr_r;
    assign pad_data_out = pad_dout_r;
    assign pad_data_oe  = pad_oe_r;
    assign phase        = state_r;

endmodule

// File: tb/tb_bus_phase_sequencer.sv
// Scoreboard bench for bus_phase_sequencer: stimulus pushes expected completions,
// a monitor pops them on every done pulse; pad phases are checked cycle by cycle.
module tb_bus_phase_sequencer;

    localparam int WM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        ext_rdy = 1'b0;
    logic [7:0]  pad_data_in = 8'h00;
    logic [7:0]  rdata, pad_addr, pad_data_out, pad_data_oe;
    logic        done, err, busy;
    logic [1:0]  phase;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] rd_model = 8'h00;

    typedef struct {
        logic [7:0] rd;
        logic       er;
        int         at;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    bus_phase_sequencer #(.WAIT_MAX(WM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .err(err), .busy(busy), .ext_rdy(ext_rdy),
        .pad_addr(pad_addr), .pad_data_in(pad_data_in), .pad_data_out(pad_data_out),
        .pad_data_oe(pad_data_oe), .phase(phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want no done (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rdata", {8'h00, rdata}, {8'h00, mon_e.rd});
                chk("err", {15'h0, err}, {15'h0, mon_e.er});
                chk("done_cycle", cyc[15:0], mon_e.at[15:0]);
            end
        end
    end

    // Called at a negedge with the DUT able to sample req on the next edge.
    // waits = DATA cycles with ext_rdy low before it rises (>WM means never).
    task automatic xfer(input string tag, input logic w, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] din, input int waits,
                        input logic keep);
        int   dcyc;
        logic er;
        exp_t e;
        er   = (waits > WM);
        dcyc = er ? WM + 1 : waits + 1;
`ifndef BUS_WAIT_STATE_EN
        er   = 1'b0;
        dcyc = 1;
`endif
        req = 1'b1; we = w; addr = a; wdata = wd; pad_data_in = din;
        ext_rdy = (waits == 0);
        if (!w && !er) rd_model = din;
        e.rd = rd_model;
        e.er = er;
        e.at = cyc + 3 + dcyc;
        sb.push_back(e);

        @(negedge clk);
        chk({tag, "_ah_phase"}, {14'h0, phase}, 16'd1);
        chk({tag, "_ah_addr"}, {8'h00, pad_addr}, {8'h00, a[15:8]});
        chk({tag, "_ah_dout"}, {8'h00, pad_data_out}, {15'h0, ~w});
        chk({tag, "_ah_oe"}, {8'h00, pad_data_oe}, 16'h0001);
        chk({tag, "_ah_busy"}, {15'h0, busy}, 16'd1);

        @(negedge clk);
        chk({tag, "_al_phase"}, {14'h0, phase}, 16'd2);
        chk({tag, "_al_addr"}, {8'h00, pad_addr}, {8'h00, a[7:0]});
        chk({tag, "_al_dout"}, {8'h00, pad_data_out}, w ? {8'h00, wd} : 16'h0000);
        chk({tag, "_al_oe"}, {8'h00, pad_data_oe}, w ? 16'h00FF : 16'h0000);

        for (int i = 0; i < dcyc; i++) begin
            @(negedge clk);
            ext_rdy = (i >= waits);
            chk({tag, "_d_phase"}, {14'h0, phase}, 16'd3);
            chk({tag, "_d_addr"}, {8'h00, pad_addr}, {8'h00, a[7:0]});
            chk({tag, "_d_dout"}, {8'h00, pad_data_out}, w ? {8'h00, wd} : 16'h0000);
            chk({tag, "_d_oe"}, {8'h00, pad_data_oe}, w ? 16'h00FF : 16'h0000);
            chk({tag, "_d_busy"}, {15'h0, busy}, 16'd1);
        end

        @(negedge clk);
        chk({tag, "_done_seen"}, {15'h0, done}, 16'd1);
        chk({tag, "_end_phase"}, {14'h0, phase}, 16'd0);
        chk({tag, "_end_busy"}, {15'h0, busy}, 16'd0);
        chk({tag, "_end_oe"}, {8'h00, pad_data_oe}, 16'h0000);
        req = keep;
        ext_rdy = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, {8'h00, rdata}, 16'h0000);
        chk({tag, "_done"}, {15'h0, done}, 16'd0);
        chk({tag, "_err"}, {15'h0, err}, 16'd0);
        chk({tag, "_busy"}, {15'h0, busy}, 16'd0);
        chk({tag, "_paddr"}, {8'h00, pad_addr}, 16'h0000);
        chk({tag, "_dout"}, {8'h00, pad_data_out}, 16'h0000);
        chk({tag, "_oe"}, {8'h00, pad_data_oe}, 16'h0000);
        chk({tag, "_phase"}, {14'h0, phase}, 16'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        xfer("rd1", 1'b0, 16'hA5C3, 8'h00, 8'h3C, 0, 1'b0);
        xfer("wr1", 1'b1, 16'h0200, 8'h5A, 8'hAA, 0, 1'b0);
        @(negedge clk);

        xfer("b2b_a", 1'b0, 16'h1234, 8'h00, 8'h81, 0, 1'b1);
        xfer("b2b_b", 1'b1, 16'hFEDC, 8'hC6, 8'h00, 0, 1'b0);
        @(negedge clk);

`ifndef BUS_WAIT_STATE_EN
        xfer("rdy_ign", 1'b0, 16'h00FF, 8'h00, 8'h42, 5, 1'b0);
        @(negedge clk);
`endif

        // Asynchronous reset while a write is in AL
        req = 1'b1; we = 1'b1; addr = 16'hBEEF; wdata = 8'h99;
        @(negedge clk);
        @(negedge clk);
        chk("mid_al_phase", {14'h0, phase}, 16'd2);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        req = 1'b0;
        rd_model = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_phase", {14'h0, phase}, 16'd0);
        xfer("after_rst", 1'b0, 16'h4321, 8'h00, 8'h5E, 0, 1'b0);
        @(negedge clk);

`ifdef BUS_WAIT_STATE_EN
        xfer("ws2", 1'b0, 16'h3000, 8'h00, 8'h77, 2, 1'b0);
        xfer("ws_to", 1'b0, 16'h3002, 8'h00, 8'hEE, 99, 1'b0);
        xfer("ws_edge", 1'b0, 16'h3001, 8'h00, 8'h66, 3, 1'b0);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
